// File: rtl/sys_ctrl_pkg.sv
// Shared command codes, operand addresses and FSM state encoding for sys_ctrl.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUN_S,
    ALU_WAIT,
    SEND
  } sys_ctrl_state_t;

endpackage

// File: rtl/sys_ctrl_tx_buf.sv
// Two-byte load/shift buffer feeding the TX FIFO, low byte first, stalling on FIFO_FULL.
module sys_ctrl_tx_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load1_i,
  input  logic                    load2_i,
  input  logic [2*DATA_WIDTH-1:0] data16_i,
  input  logic                    fifo_full_i,
  output logic [DATA_WIDTH-1:0]   tx_p_data_o,
  output logic                    tx_d_vld_o,
  output logic                    done_o
);

  logic [2*DATA_WIDTH-1:0] buf_q;
  logic [2*DATA_WIDTH-1:0] buf_d;
  logic [1:0]              cnt_q;
  logic [1:0]              cnt_d;

  // A load and the first issue share one edge, so the first byte leaves in the cycle after the load.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (load2_i) begin
      buf_d = data16_i;
      cnt_d = 2'd2;
    end else if (load1_i) begin
      buf_d = {{DATA_WIDTH{1'b0}}, data16_i[DATA_WIDTH-1:0]};
      cnt_d = 2'd1;
    end
  end

  // Done when empty, or when the last byte is being issued at this edge.
  assign done_o = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && !fifo_full_i);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      tx_p_data_o <= '0;
      tx_d_vld_o  <= 1'b0;
    end else begin
      tx_d_vld_o <= 1'b0;
      if ((cnt_d != 2'd0) && !fifo_full_i) begin
        tx_p_data_o <= buf_d[DATA_WIDTH-1:0];
        tx_d_vld_o  <= 1'b1;
        buf_q       <= buf_d >> DATA_WIDTH;
        cnt_q       <= cnt_d - 2'd1;
      end else begin
        buf_q <= buf_d;
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer: turns UART byte frames into register-file accesses and ALU operations, returns results to TX.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    RF_RD_EN,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    FIFO_FULL
);

  sys_ctrl_state_t         state_q;
  logic                    load1;
  logic                    load2;
  logic                    send_done;
  logic [2*DATA_WIDTH-1:0] tx_data16;

  assign load1     = (state_q == RD_WAIT)  && RF_RD_VLD;
  assign load2     = (state_q == ALU_WAIT) && ALU_OUT_VLD;
  assign tx_data16 = load2 ? ALU_OUT : {{DATA_WIDTH{1'b0}}, RF_RD_DATA};

  sys_ctrl_tx_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx_buf (
    .CLK        (CLK),
    .RST        (RST),
    .load1_i    (load1),
    .load2_i    (load2),
    .data16_i   (tx_data16),
    .fifo_full_i(FIFO_FULL),
    .tx_p_data_o(TX_P_DATA),
    .tx_d_vld_o (TX_D_VLD),
    .done_o     (send_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      RF_ADDR    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_WR_DATA <= '0;
      RF_RD_EN   <= 1'b0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      CLK_EN     <= 1'b0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_RF_WR)        state_q <= WR_ADDR;
            else if (RX_P_DATA == CMD_RF_RD)   state_q <= RD_ADDR;
            else if (RX_P_DATA == CMD_ALU_OP)  state_q <= OP_A;
            else if (RX_P_DATA == CMD_ALU_NOP) state_q <= ALU_FUN_S;
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WR_DATA <= RX_P_DATA;
            RF_WR_EN   <= 1'b1;
            state_q    <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
            RF_RD_EN <= 1'b1;
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (RF_RD_VLD) state_q <= SEND;
        end
        OP_A: begin
          if (RX_D_VLD) begin
            RF_ADDR    <= ADDR_WIDTH'(OPA_ADDR);
            RF_WR_DATA <= RX_P_DATA;
            RF_WR_EN   <= 1'b1;
            state_q    <= OP_B;
          end
        end
        OP_B: begin
          if (RX_D_VLD) begin
            RF_ADDR    <= ADDR_WIDTH'(OPB_ADDR);
            RF_WR_DATA <= RX_P_DATA;
            RF_WR_EN   <= 1'b1;
            state_q    <= ALU_FUN_S;
          end
        end
        ALU_FUN_S: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[3:0];
            ALU_EN  <= 1'b1;
            CLK_EN  <= 1'b1;
            state_q <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            CLK_EN  <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (send_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl with behavioural register-file and ALU neighbours.
module tb_sys_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic [7:0]  RF_WR_DATA;
  logic        RF_RD_EN;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_VLD;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic        CLK_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        FIFO_FULL;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_cnt  = 0;
  int clken_cyc = 0;
  logic alu_live;

  logic [7:0]  tx_q[$];
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  fun_q[$];

  sys_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RF_ADDR    (RF_ADDR),
    .RF_WR_EN   (RF_WR_EN),
    .RF_WR_DATA (RF_WR_DATA),
    .RF_RD_EN   (RF_RD_EN),
    .RF_RD_DATA (RF_RD_DATA),
    .RF_RD_VLD  (RF_RD_VLD),
    .ALU_FUN    (ALU_FUN),
    .ALU_EN     (ALU_EN),
    .CLK_EN     (CLK_EN),
    .ALU_OUT    (ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .FIFO_FULL  (FIFO_FULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b0, RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_FUN, ALU_EN, CLK_EN,
            TX_P_DATA, TX_D_VLD};
  endfunction

  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] a16, b16;
    a16 = {8'h00, a};
    b16 = {8'h00, b};
    case (f)
      4'h0: return a16 + b16;
      4'h1: return a16 - b16;
      4'h2: return a16 * b16;
      4'h3: return (b != 8'h00) ? a16 / b16 : 16'h0000;
      4'h4: return a16 & b16;
      4'h5: return a16 | b16;
      4'h6: return {8'h00, ~(a & b)};
      4'h7: return {8'h00, ~(a | b)};
      4'h8: return a16 ^ b16;
      4'h9: return {8'h00, ~(a ^ b)};
      4'hA: return (a == b) ? 16'd1 : 16'd0;
      4'hB: return (a > b)  ? 16'd2 : 16'd0;
      4'hC: return (a < b)  ? 16'd3 : 16'd0;
      4'hD: return a16 >> 1;
      4'hE: return a16 << 1;
      default: return 16'h0000;
    endcase
  endfunction

  // Register-file neighbour: one-cycle read latency, contents preset to i*0x11.
  logic [7:0] rf[16];
  initial for (int i = 0; i < 16; i++) rf[i] = 8'(i * 17);
  always @(posedge CLK) begin
    if (RF_WR_EN) rf[RF_ADDR] <= RF_WR_DATA;
    if (!RST) RF_RD_VLD <= 1'b0;
    else RF_RD_VLD <= RF_RD_EN;
    if (RF_RD_EN) RF_RD_DATA <= rf[RF_ADDR];
  end

  // ALU neighbour: registers its result one edge after ALU_EN, or later while alu_live is low.
  logic       alu_pend;
  logic [3:0] alu_fun_l;
  always @(posedge CLK) begin
    if (!RST) begin
      ALU_OUT_VLD <= 1'b0;
      ALU_OUT     <= '0;
      alu_pend    <= 1'b0;
      alu_fun_l   <= '0;
    end else begin
      ALU_OUT_VLD <= 1'b0;
      if (ALU_EN && alu_live) begin
        ALU_OUT     <= alu_ref(ALU_FUN, rf[0], rf[1]);
        ALU_OUT_VLD <= 1'b1;
      end else if (ALU_EN) begin
        alu_pend  <= 1'b1;
        alu_fun_l <= ALU_FUN;
      end else if (alu_pend && alu_live) begin
        ALU_OUT     <= alu_ref(alu_fun_l, rf[0], rf[1]);
        ALU_OUT_VLD <= 1'b1;
        alu_pend    <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    logic [11:0] e;
    if (TX_D_VLD) begin
      tx_cnt++;
      check("tx_pending", 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) check("tx_byte", 32'(TX_P_DATA), 32'(tx_q.pop_front()));
    end
    if (RF_WR_EN) begin
      check("wr_pending", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("wr_addr_data", 32'({RF_ADDR, RF_WR_DATA}), 32'(e));
      end
    end
    if (RF_RD_EN) begin
      check("rd_pending", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) check("rd_addr", 32'(RF_ADDR), 32'(rd_q.pop_front()));
    end
    if (ALU_EN) begin
      check("alu_pending", 32'(fun_q.size() != 0), 32'd1);
      if (fun_q.size() != 0) check("alu_fun", 32'(ALU_FUN), 32'(fun_q.pop_front()));
    end
    if (CLK_EN) clken_cyc++;
  end

  // Called at a negedge; returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (tx_q.size() + wr_q.size() + rd_q.size() + fun_q.size()) != 0; i++)
      @(negedge CLK);
    repeat (3) @(negedge CLK);
    check({tag, "_drain"}, 32'(tx_q.size() + wr_q.size() + rd_q.size() + fun_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [31:0] snap;
    RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = '0; FIFO_FULL = 1'b0; alu_live = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_outs", outs(), 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Write then read back
    wr_q.push_back({4'h5, 8'h3C});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    rd_q.push_back(4'h5); tx_q.push_back(8'h3C);
    send_byte(8'hBB); send_byte(8'h05);
    check("rd_en_lat", 32'(RF_RD_EN), 32'd1);
    @(negedge CLK); @(negedge CLK);
    check("rd_tx_lat", 32'(TX_D_VLD), 32'd1);
    drain("wr_rd");

    // Multiply with operands, latency of the ALU path
    wr_q.push_back({4'h0, 8'h0F}); wr_q.push_back({4'h1, 8'h10});
    fun_q.push_back(4'h2); tx_q.push_back(8'hF0); tx_q.push_back(8'h00);
    send_byte(8'hCC); send_byte(8'h0F); send_byte(8'h10); send_byte(8'h02);
    check("alu_en_lat", 32'({ALU_EN, CLK_EN}), 32'b11);
    @(negedge CLK);
    check("alu_n2", 32'({ALU_EN, CLK_EN, ALU_OUT_VLD}), 32'b011);
    @(negedge CLK);
    check("alu_tx1", 32'({TX_D_VLD, CLK_EN}), 32'b10);
    @(negedge CLK);
    check("alu_tx2", 32'(TX_D_VLD), 32'd1);
    drain("mul");

    // No-operand op on 0x09 / 0x03 with fun 0xB (upper nibble ignored)
    wr_q.push_back({4'h0, 8'h09}); wr_q.push_back({4'h1, 8'h03});
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h09);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03);
    drain("preload");
    clken_cyc = 0;
    fun_q.push_back(4'hB); tx_q.push_back(8'h02); tx_q.push_back(8'h00);
    send_byte(8'hDD); send_byte(8'h5B);
    drain("nop_op");
    check("clk_en_cycles", 32'(clken_cyc), 32'd2);
    check("alu_fun_hold", 32'(ALU_FUN), 32'hB);

    // Back-pressure across the whole frame
    FIFO_FULL = 1'b1;
    t0 = tx_cnt;
    wr_q.push_back({4'h0, 8'h12}); wr_q.push_back({4'h1, 8'h34});
    fun_q.push_back(4'h0); tx_q.push_back(8'h46); tx_q.push_back(8'h00);
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    repeat (10) @(negedge CLK);
    check("bp_no_tx", 32'(tx_cnt - t0), 32'd0);
    FIFO_FULL = 1'b0;
    drain("bp");
    check("bp_tx_count", 32'(tx_cnt - t0), 32'd2);

    // FIFO_FULL rising between the two result bytes: 0x12*0x34 = 0x03A8
    t0 = tx_cnt;
    fun_q.push_back(4'h2); tx_q.push_back(8'hA8); tx_q.push_back(8'h03);
    send_byte(8'hDD); send_byte(8'h02);
    @(negedge CLK); @(negedge CLK);
    FIFO_FULL = 1'b1;
    repeat (4) @(negedge CLK);
    check("stall_one_byte", 32'(tx_cnt - t0), 32'd1);
    FIFO_FULL = 1'b0;
    drain("stall");
    check("stall_tx_count", 32'(tx_cnt - t0), 32'd2);

    // Garbage byte in IDLE, then a normal frame
    snap = outs();
    send_byte(8'h7E);
    repeat (3) @(negedge CLK);
    check("garbage_outs", outs(), snap);
    wr_q.push_back({4'h7, 8'h5A});
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h5A);
    drain("after_garbage");

    // Bytes arriving during ALU_WAIT are dropped: 0x12 & 0x34 = 0x10
    alu_live = 1'b0;
    t0 = tx_cnt;
    fun_q.push_back(4'h4);
    send_byte(8'hDD); send_byte(8'h04);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h77);
    send_byte(8'hBB); send_byte(8'h02);
    repeat (5) @(negedge CLK);
    check("wait_no_tx", 32'(tx_cnt - t0), 32'd0);
    check("wait_clk_en", 32'(CLK_EN), 32'd1);
    tx_q.push_back(8'h10); tx_q.push_back(8'h00);
    alu_live = 1'b1;
    drain("drop");
    check("drop_tx_count", 32'(tx_cnt - t0), 32'd2);
    check("drop_rf2", 32'(rf[2]), 32'h22);

    // Reset mid-frame, then a read completes normally
    send_byte(8'hAA); send_byte(8'h03);
    RST = 1'b0;
    #1;
    check("rst_mid_outs", outs(), 32'd0);
    @(negedge CLK);
    check("rst_mid_outs2", outs(), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    rd_q.push_back(4'h3); tx_q.push_back(8'h33);
    send_byte(8'hBB); send_byte(8'h03);
    drain("post_rst");
    check("rf3_untouched", 32'(rf[3]), 32'h33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
